// File: rtl/lives_digit_render.sv
// lives_digit_render
//
// Converts a binary lives count to three BCD digits and renders them as a
// 24x16 pixel field: three 8x16 glyphs from an external digit font ROM.
//
// A conversion runs a serial double-dabble over 10 shift cycles and then
// 1 result cycle. The finished digits are held in a result register and
// copied to the displayed digits only on a frame_start pulse. Rendering
// always reads the displayed digits, so a frame never shows a mix of old
// and new digits.
//
// Parameters
//   X0, Y0        top-left pixel of the 3-digit field
//   BLANK_LEADING 1: suppress leading zero digits (the ones digit is always drawn)
//
// Ports
//   Clk          clock, rising edge
//   Reset_n      asynchronous active-low reset
//   lives        binary lives count; values above 999 are shown as 999
//   lives_valid  one-cycle request to convert lives
//   frame_start  one-cycle pulse at frame start; commit point for new digits
//   DrawX, DrawY current pixel coordinate
//   font_addr    font ROM row address = digit*16 + row (0 outside the field)
//   font_data    font ROM row, combinational from font_addr, bit 7 = leftmost
//   pixel_on     foreground pixel, 2 cycles after the coordinate
//   busy         conversion in progress
//   disp_bcd     displayed digits {hundreds, tens, ones}
module lives_digit_render #(
  parameter int unsigned X0            = 16,
  parameter int unsigned Y0            = 8,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  lives,
  input  logic        lives_valid,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        pixel_on,
  output logic        busy,
  output logic [11:0] disp_bcd
);

  // ---------------------------------------------------------------------------
  // Binary to BCD conversion
  // ---------------------------------------------------------------------------

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam logic [3:0] LastShift = 4'd9;

  state_e      state_q, state_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  pend_val_q, pend_val_d;
  logic        pending_q, pending_d;
  logic [11:0] result_q, result_d;
  logic        new_flag_q, new_flag_d;
  logic [11:0] disp_q, disp_d;
  logic [11:0] bcd_adj;
  logic [9:0]  lives_sat;

  function automatic logic [3:0] dabble(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  assign lives_sat = (lives > 10'd999) ? 10'd999 : lives;

  // Correction applied to every digit before each shift.
  assign bcd_adj = {dabble(bcd_q[11:8]), dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;
    result_d   = result_q;
    new_flag_d = new_flag_q;
    disp_d     = disp_q;

    // Commit uses the registered flag, so a result written on this same edge
    // waits for the next frame_start. The DONE branch below sets the flag
    // after this clear, so setting wins over clearing.
    if (frame_start && new_flag_q) begin
      disp_d     = result_q;
      new_flag_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (lives_valid) begin
          bin_d   = lives_sat;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end

      StShift: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == LastShift) begin
          state_d = StDone;
        end
        // Requests during a conversion queue up; only the latest is kept.
        if (lives_valid) begin
          pend_val_d = lives_sat;
          pending_d  = 1'b1;
        end
      end

      StDone: begin
        result_d   = bcd_q;
        new_flag_d = 1'b1;
        bcd_d      = '0;
        cnt_d      = '0;
        if (lives_valid) begin
          // A request arriving right now is newer than anything pending.
          bin_d     = lives_sat;
          pending_d = 1'b0;
          state_d   = StShift;
        end else if (pending_q) begin
          bin_d     = pend_val_q;
          pending_d = 1'b0;
          state_d   = StShift;
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      pend_val_q <= '0;
      pending_q  <= 1'b0;
      result_q   <= '0;
      new_flag_q <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
      result_q   <= result_d;
      new_flag_q <= new_flag_d;
      disp_q     <= disp_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign disp_bcd = disp_q;

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  //   stage 1: field decode, digit select, font address
  //   stage 2: pick the font bit for the column
  // ---------------------------------------------------------------------------

  localparam logic [10:0] XLo = 11'(X0);
  localparam logic [10:0] XHi = 11'(X0 + 24);
  localparam logic [10:0] YLo = 11'(Y0);
  localparam logic [10:0] YHi = 11'(Y0 + 16);

  logic [9:0]  dx, dy;
  logic        in_box_c;
  logic [1:0]  slot_c;
  logic [3:0]  digit_c;
  logic        blank_c;
  logic [10:0] addr_c;
  logic        hund_zero, tens_zero;

  logic [10:0] font_addr_q;
  logic        in_box_q;
  logic [2:0]  col_q;
  logic        blank_q;
  logic        pixel_on_q, pixel_on_d;

  // Offsets are only meaningful inside the field, where they fit in 5/4 bits.
  assign dx = DrawX - 10'(X0);
  assign dy = DrawY - 10'(Y0);

  logic unused_offset_bits;
  assign unused_offset_bits = ^{dx[9:5], dy[9:4]};

  assign in_box_c = ({1'b0, DrawX} >= XLo) && ({1'b0, DrawX} < XHi) &&
                    ({1'b0, DrawY} >= YLo) && ({1'b0, DrawY} < YHi);

  // Inside the field dx < 24, so dx/8 is dx[4:3] in 0..2.
  assign slot_c = dx[4:3];

  assign hund_zero = (disp_q[11:8] == 4'd0);
  assign tens_zero = (disp_q[7:4] == 4'd0);

  always_comb begin
    digit_c = 4'd0;
    blank_c = 1'b0;
    case (slot_c)
      2'd0: begin
        digit_c = disp_q[11:8];
        blank_c = BLANK_LEADING && hund_zero;
      end
      2'd1: begin
        digit_c = disp_q[7:4];
        blank_c = BLANK_LEADING && hund_zero && tens_zero;
      end
      2'd2: begin
        digit_c = disp_q[3:0];
        blank_c = 1'b0;
      end
      default: begin
        digit_c = 4'd0;
        blank_c = 1'b0;
      end
    endcase
  end

  assign addr_c = in_box_c ? {3'b000, digit_c, dy[3:0]} : 11'd0;

  assign pixel_on_d = font_data[3'd7 - col_q] & in_box_q & ~blank_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      font_addr_q <= '0;
      in_box_q    <= 1'b0;
      col_q       <= '0;
      blank_q     <= 1'b0;
      pixel_on_q  <= 1'b0;
    end else begin
      font_addr_q <= addr_c;
      in_box_q    <= in_box_c;
      col_q       <= dx[2:0];
      blank_q     <= in_box_c & blank_c;
      pixel_on_q  <= pixel_on_d;
    end
  end

  assign font_addr = font_addr_q;
  assign pixel_on  = pixel_on_q;

endmodule
